// File: rtl/fub_queue.sv
// Functional-unit output buffer: a collapsing, age-ordered queue that offers its
// oldest result to the CDB, with branch-mask squash/clear and sticky overflow.
module fub_queue #(
    parameter int  DEPTH   = 4,
    parameter int  DATA_W  = 64,
    parameter int  TAG_W   = 6,
    parameter int  BMASK_W = 4,
    parameter int  BSPTR_W = 2,
    localparam int CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               fu_done,
    input  logic [DATA_W-1:0]  fu_result,
    input  logic [TAG_W-1:0]   fu_tagDest,
    input  logic [BMASK_W-1:0] fu_bmask,
    input  logic               cdb_stall,
    input  logic               br_fub_done_in,
    input  logic               br_fub_pred_wrong_in,
    input  logic [BSPTR_W-1:0] br_fub_bs_ptr_in,
    output logic               fub_busy,
    output logic               fub_valid,
    output logic [DATA_W-1:0]  fub_result,
    output logic [TAG_W-1:0]   fub_tagDest,
    output logic [BMASK_W-1:0] fub_bmask,
    output logic [CNT_W-1:0]   fub_count,
    output logic               fub_overflow
);

    logic [DATA_W-1:0]  data_q  [DEPTH];
    logic [DATA_W-1:0]  data_d  [DEPTH];
    logic [TAG_W-1:0]   tag_q   [DEPTH];
    logic [TAG_W-1:0]   tag_d   [DEPTH];
    logic [BMASK_W-1:0] bmask_q [DEPTH];
    logic [BMASK_W-1:0] bmask_d [DEPTH];
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q;

    logic [BMASK_W-1:0] clr_mask;
    logic [DEPTH-1:0]   squash;
    logic [DEPTH-1:0]   keep;
    logic               mispredict, in_squash, deq, enq;

    assign mispredict = br_fub_done_in & br_fub_pred_wrong_in;

    always_comb begin
        clr_mask = '0;
        if (br_fub_done_in && !br_fub_pred_wrong_in) clr_mask[br_fub_bs_ptr_in] = 1'b1;
    end

    always_comb begin
        squash = '0;
        for (int i = 0; i < DEPTH; i++) squash[i] = mispredict & bmask_q[i][br_fub_bs_ptr_in];
    end

    // Busy looks only at the registered count, so the FU never sees a path from the CDB or branch unit.
    assign fub_busy  = (count_q == CNT_W'(DEPTH));
    assign fub_valid = (count_q != '0) & ~squash[0];
    assign deq       = fub_valid & ~cdb_stall;
    assign in_squash = mispredict & fu_bmask[br_fub_bs_ptr_in];
    assign enq       = fu_done & ~fub_busy & ~in_squash;

    always_comb begin
        keep = '0;
        for (int i = 0; i < DEPTH; i++)
            keep[i] = (i < int'(count_q)) && !squash[i] && !((i == 0) && deq);
    end

    // NOTE: every _d signal gets a default before any conditional write so no latch is inferred.
    always_comb begin
        int n;
        n       = 0;
        data_d  = data_q;
        tag_d   = tag_q;
        bmask_d = bmask_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (keep[i]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (j == n) begin
                        data_d[j]  = data_q[i];
                        tag_d[j]   = tag_q[i];
                        bmask_d[j] = bmask_q[i] & ~clr_mask;
                    end
                end
                n++;
            end
        end
        if (enq) begin
            for (int j = 0; j < DEPTH; j++) begin
                if (j == n) begin
                    data_d[j]  = fu_result;
                    tag_d[j]   = fu_tagDest;
                    bmask_d[j] = fu_bmask & ~clr_mask;
                end
            end
        end
        count_d = CNT_W'(n + (enq ? 1 : 0));
    end

    // NOTE: the small entry storage is reset too, so the head outputs read zero straight out of reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i]  <= '0;
                tag_q[i]   <= '0;
                bmask_q[i] <= '0;
            end
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_q | (fu_done & fub_busy);
            data_q     <= data_d;
            tag_q      <= tag_d;
            bmask_q    <= bmask_d;
        end
    end

    assign fub_result   = data_q[0];
    assign fub_tagDest  = tag_q[0];
    assign fub_bmask    = bmask_q[0] & ~clr_mask;
    assign fub_count    = count_q;
    assign fub_overflow = overflow_q;

endmodule

// File: tb/tb_fub_queue.sv
// Self-checking bench for fub_queue: directed scenarios with literal expectations,
// then random traffic, all compared every cycle against a queue-based model.
module tb_fub_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        reset;
    logic        fu_done;
    logic [63:0] fu_result;
    logic [5:0]  fu_tagDest;
    logic [3:0]  fu_bmask;
    logic        cdb_stall;
    logic        br_fub_done_in;
    logic        br_fub_pred_wrong_in;
    logic [1:0]  br_fub_bs_ptr_in;
    logic        fub_busy;
    logic        fub_valid;
    logic [63:0] fub_result;
    logic [5:0]  fub_tagDest;
    logic [3:0]  fub_bmask;
    logic [2:0]  fub_count;
    logic        fub_overflow;

    int checks   = 0;
    int failures = 0;

    fub_queue dut (
        .clk                  (clk),
        .reset                (reset),
        .fu_done              (fu_done),
        .fu_result            (fu_result),
        .fu_tagDest           (fu_tagDest),
        .fu_bmask             (fu_bmask),
        .cdb_stall            (cdb_stall),
        .br_fub_done_in       (br_fub_done_in),
        .br_fub_pred_wrong_in (br_fub_pred_wrong_in),
        .br_fub_bs_ptr_in     (br_fub_bs_ptr_in),
        .fub_busy             (fub_busy),
        .fub_valid            (fub_valid),
        .fub_result           (fub_result),
        .fub_tagDest          (fub_tagDest),
        .fub_bmask            (fub_bmask),
        .fub_count            (fub_count),
        .fub_overflow         (fub_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [63:0] d;
        logic [5:0]  t;
        logic [3:0]  m;
    } ent_t;

    ent_t mq[$];
    bit   m_ov;

    function automatic bit squashed(input logic [3:0] m);
        return br_fub_done_in && br_fub_pred_wrong_in && m[br_fub_bs_ptr_in];
    endfunction

    function automatic logic [3:0] clr_bits();
        logic [3:0] c;
        c = 4'b0;
        if (br_fub_done_in && !br_fub_pred_wrong_in) c[br_fub_bs_ptr_in] = 1'b1;
        return c;
    endfunction

    always @(negedge reset) begin
        mq.delete();
        m_ov = 1'b0;
    end

    always @(posedge clk) begin
        ent_t nq[$];
        ent_t e;
        bit   full, head_ok, deq_e;
        if (reset) begin
            full    = (mq.size() == DEPTH);
            head_ok = (mq.size() > 0) && !squashed(mq[0].m);
            deq_e   = head_ok && !cdb_stall;
            nq      = {};
            foreach (mq[i]) begin
                if (!(i == 0 && deq_e) && !squashed(mq[i].m)) begin
                    e   = mq[i];
                    e.m = e.m & ~clr_bits();
                    nq.push_back(e);
                end
            end
            if (fu_done) begin
                if (full) m_ov = 1'b1;
                else if (!squashed(fu_bmask)) begin
                    e.d = fu_result;
                    e.t = fu_tagDest;
                    e.m = fu_bmask & ~clr_bits();
                    nq.push_back(e);
                end
            end
            mq = nq;
        end
    end

    always @(negedge clk) begin
        int cnt;
        if (reset) begin
            cnt = mq.size();
            check("count", fub_count, cnt);
            check("busy", fub_busy, cnt == DEPTH);
            check("overflow", fub_overflow, m_ov);
            check("valid", fub_valid, (cnt > 0) && !squashed(mq[0].m));
            if (cnt > 0) begin
                check("head_result", fub_result, mq[0].d);
                check("head_tag", fub_tagDest, mq[0].t);
                check("head_bmask", fub_bmask, mq[0].m & ~clr_bits());
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_idle();
        fu_done              = 1'b0;
        fu_result            = 64'b0;
        fu_tagDest           = 6'b0;
        fu_bmask             = 4'b0;
        br_fub_done_in       = 1'b0;
        br_fub_pred_wrong_in = 1'b0;
        br_fub_bs_ptr_in     = 2'b0;
    endtask

    task automatic set_in(input bit done, input logic [5:0] tag, input logic [3:0] bm,
                          input bit bd, input bit pw, input logic [1:0] ptr);
        fu_done              = done;
        fu_result            = {$urandom, $urandom};
        fu_tagDest           = tag;
        fu_bmask             = bm;
        br_fub_done_in       = bd;
        br_fub_pred_wrong_in = pw;
        br_fub_bs_ptr_in     = ptr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        set_idle();
    endtask

    task automatic enq(input logic [5:0] tag, input logic [3:0] bm);
        set_in(1'b1, tag, bm, 1'b0, 1'b0, 2'd0);
        tick();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, fub_valid, 0);
        check({tag, "_count"}, fub_count, 0);
        check({tag, "_busy"}, fub_busy, 0);
        check({tag, "_overflow"}, fub_overflow, 0);
        check({tag, "_result"}, fub_result, 0);
        check({tag, "_tag"}, fub_tagDest, 0);
        check({tag, "_bmask"}, fub_bmask, 0);
    endtask

    // Reset is asserted and released between clock edges.
    task automatic do_reset(input string tag);
        @(posedge clk);
        #3 reset = 1'b0;
        #1 check_reset_state(tag);
        #3 reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        set_idle();
        cdb_stall = 1'b0;
        reset     = 1'b1;
        #1 reset = 1'b0;
        #1 check_reset_state("por");
        #10 reset = 1'b1;
        @(posedge clk);
        #1;

        // Stream: one in, one out per cycle, occupancy stays at one.
        cdb_stall = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            enq(6'(t), 4'b0000);
            check("stream_valid", fub_valid, 1);
            check("stream_tag", fub_tagDest, t);
            check("stream_count", fub_count, 1);
        end
        tick();
        check("stream_empty", fub_count, 0);

        // Fill, overflow, then drain in order.
        cdb_stall = 1'b1;
        for (int t = 10; t <= 13; t++) enq(6'(t), 4'b0000);
        check("fill_count", fub_count, 4);
        check("fill_busy", fub_busy, 1);
        enq(6'd14, 4'b0000);
        check("fill_overflow", fub_overflow, 1);
        check("fill_count_hold", fub_count, 4);
        cdb_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("drain_valid", fub_valid, 1);
            check("drain_tag", fub_tagDest, 10 + k);
            tick();
        end
        check("drain_empty", fub_count, 0);
        check("overflow_sticky", fub_overflow, 1);
        do_reset("rst1");

        // Mid-queue squash keeps survivors in order.
        cdb_stall = 1'b1;
        enq(6'd20, 4'b0000);
        enq(6'd21, 4'b0010);
        enq(6'd22, 4'b0000);
        enq(6'd23, 4'b0010);
        check("midsq_busy_before", fub_busy, 1);
        set_in(1'b0, 6'd0, 4'b0, 1'b1, 1'b1, 2'd1);
        tick();
        check("midsq_count", fub_count, 2);
        check("midsq_busy_after", fub_busy, 0);
        check("midsq_head0", fub_tagDest, 20);
        cdb_stall = 1'b0;
        tick();
        check("midsq_head1", fub_tagDest, 22);
        check("midsq_count1", fub_count, 1);
        tick();
        do_reset("rst2");

        // Head squash with a squashed incoming result in the same cycle.
        cdb_stall = 1'b1;
        enq(6'd30, 4'b0001);
        enq(6'd31, 4'b0000);
        cdb_stall = 1'b0;
        set_in(1'b1, 6'd32, 4'b0001, 1'b1, 1'b1, 2'd0);
        #1 check("headsq_valid", fub_valid, 0);
        tick();
        check("headsq_count", fub_count, 1);
        check("headsq_tag", fub_tagDest, 31);
        check("headsq_overflow", fub_overflow, 0);
        tick();

        // Correct prediction clears the resolving bit everywhere.
        cdb_stall = 1'b1;
        enq(6'd40, 4'b0110);
        enq(6'd41, 4'b0110);
        set_in(1'b0, 6'd0, 4'b0, 1'b1, 1'b0, 2'd2);
        #1 check("clear_same_cycle", fub_bmask, 4'b0010);
        tick();
        check("clear_stored", fub_bmask, 4'b0010);
        set_in(1'b0, 6'd0, 4'b0, 1'b1, 1'b1, 2'd2);
        tick();
        check("clear_no_squash", fub_count, 2);
        cdb_stall = 1'b0;
        tick();
        tick();

        // Asynchronous reset with entries held.
        cdb_stall = 1'b1;
        enq(6'd50, 4'b0000);
        enq(6'd51, 4'b0000);
        enq(6'd52, 4'b0000);
        check("held_count", fub_count, 3);
        do_reset("rst3");
        cdb_stall = 1'b0;
        enq(6'd60, 4'b0000);
        check("post_rst_valid", fub_valid, 1);
        check("post_rst_tag", fub_tagDest, 60);
        check("post_rst_count", fub_count, 1);
        tick();

        // Random traffic checked by the model every cycle.
        for (int k = 0; k < 1500; k++) begin
            cdb_stall = ($urandom_range(0, 9) < 4);
            set_in($urandom_range(0, 1) == 1 && (!fub_busy || $urandom_range(0, 19) == 0),
                   6'($urandom), 4'($urandom),
                   $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 2'($urandom));
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fub_queue.md
# fub_queue

Parametrised functional-unit output buffer that sits between one execute-stage FU and its CDB arbitration port. It holds up to DEPTH completed results in age order and presents the oldest to the CDB. It squashes or updates entries on branch resolution using per-entry branch masks. It generalises the fixed two-entry FU buffer to configurable depth, with an occupancy count, same-cycle squash of the head and of the incoming result, and a sticky overflow flag.

## Interface
- DEPTH, 4: entry count, ≥2
- DATA_W, 64: result width (DATA)
- TAG_W, 6: destination physical-register tag width (PHYS_REG)
- BMASK_W, 4: branch-mask width (B_MASK); one bit per branch-stack slot
- BSPTR_W, 2: branch-stack pointer width (BS_PTR), $clog2(BMASK_W)
- clk  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- fu_done  in  1  FU has a result this cycle
- fu_result  in  DATA_W  result data
- fu_tagDest  in  TAG_W  destination tag
- fu_bmask  in  BMASK_W  branch dependencies of the result
- cdb_stall  in  1  CDB did not grant this port this cycle
- br_fub_done_in  in  1  a branch resolves this cycle
- br_fub_pred_wrong_in  in  1  resolving branch mispredicted (valid with done)
- br_fub_bs_ptr_in  in  BSPTR_W  branch-stack slot of the resolving branch
- fub_busy  out  1  buffer full; FU must not assert fu_done
- fub_valid  out  1  head entry offered to CDB
- fub_result  out  DATA_W  head result
- fub_tagDest  out  TAG_W  head tag
- fub_bmask  out  BMASK_W  head mask with any resolving bit cleared
- fub_count  out  $clog2(DEPTH+1)  occupied entries (registered)
- fub_overflow  out  1  sticky: fu_done seen while fub_busy

## Operation
- Storage is a collapsing queue. Slot 0 is the oldest entry. Valid entries are always contiguous from slot 0.
- Squash condition S(e) = br_fub_done_in & br_fub_pred_wrong_in & e.bmask[br_fub_bs_ptr_in].
- Clear condition: br_fub_done_in & ~br_fub_pred_wrong_in clears bit br_fub_bs_ptr_in in every stored mask and in the incoming mask.
- Head offer: fub_valid = valid[0] & ~S(slot0). fub_result, fub_tagDest and fub_bmask come combinationally from slot 0. fub_bmask has the resolving bit cleared on a clear.
- Dequeue: fub_valid & ~cdb_stall removes slot 0 at the edge.
- Enqueue: fu_done & ~fub_busy & ~S(incoming) writes the result behind the surviving entries, with the updated mask.
- A squashed incoming result is dropped silently and is not counted as an overflow.
- Next state each edge:
  - remove the dequeued head and all squashed entries;
  - compact the survivors in order;
  - append the enqueued entry;
  - fub_count = number of survivors plus the enqueued entry, if any.
- fub_busy = (fub_count == DEPTH). It is derived from registered state only, so it has no combinational path from cdb_stall or the branch inputs.
- Overflow: fu_done & fub_busy drops the input and sets fub_overflow. The flag is cleared only by reset.
- br_fub_done_in low: pred_wrong and bs_ptr are ignored.
- Reset, asserted asynchronously at any time, including mid-squash:
  - all valid bits and fub_count go to 0;
  - fub_valid, fub_busy and fub_overflow go to 0;
  - fub_result, fub_tagDest and fub_bmask go to 0.

## Timing
- Latency: fu_done in cycle N gives fub_valid in cycle N+1 at the earliest. There is no input-to-output bypass.
- Throughput: one enqueue and one dequeue per cycle, sustained, when not stalled.
- Squash takes effect in the same cycle: a squashed head is never offered, even if cdb_stall is low.
- Squashed entries free space at the next edge. fub_busy can fall the cycle after the squash.
- Full with simultaneous dequeue: fub_busy is still high that cycle, so the FU holds. The count drops to DEPTH-1 next cycle.
- Empty with cdb_stall high: no effect.
- Enqueue, dequeue and squash in the same cycle all apply at one edge.

## Test plan
- Stream with no stall: fu_done for 5 consecutive cycles with tags 1..5, cdb_stall=0.
  - Required: fub_valid from cycle 2 with tags 1..5 in order.
  - fub_count never exceeds 1.
- Fill and backpressure: DEPTH=4, cdb_stall=1, tags 10..13 enqueued.
  - Required: fub_count=4 and fub_busy=1.
  - A fifth fu_done sets fub_overflow=1 and tag 14 is lost.
  - Releasing the stall drains tags 10..13 in order.
- Mid-queue squash: entries with bmasks 0000, 0010, 0000, 0010, then a mispredict with ptr=1.
  - Required: next cycle fub_count=2 with the order preserved (entries 0 and 2).
  - fub_busy falls.
- Head squash plus incoming: head bmask 0001, incoming fu_bmask 0001 with fu_done, mispredict with ptr=0, cdb_stall=0.
  - Required: fub_valid=0 that cycle and no CDB grant is consumed.
  - The incoming result is dropped and fub_overflow stays 0.
- Correct prediction: entries with bmask 0110, branch done with pred_wrong=0 and ptr=2.
  - Required: fub_bmask=0010 in the same cycle and stored masks are 0010 next cycle.
  - A later mispredict with ptr=2 squashes nothing.
- Asynchronous reset: assert reset low between clock edges with 3 entries held.
  - Required: fub_valid, fub_count, fub_busy and fub_overflow are 0 immediately, without waiting for an edge.
  - After release, the first enqueue appears at slot 0.
